// File: rtl/alu_ctrl_decode_queue_if.sv
// alu_ctrl_decode_queue_if: fetch-side and execute-side handshake bundle
// for the ALU-control decode queue, plus the occupancy count.
interface alu_ctrl_decode_queue_if #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_alu_ctrl;
    logic             out_imm_sel;
    logic             out_is_branch;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [CW-1:0]    count;

    modport master (
        output flush, in_valid, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_alu_ctrl, out_imm_sel,
        input  out_is_branch, out_illegal, out_tag, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_alu_ctrl, out_imm_sel,
        output out_is_branch, out_illegal, out_tag, count
    );
endinterface

// File: rtl/alu_ctrl_decode_queue.sv
// alu_ctrl_decode_queue: RV32I ALU-control decoder feeding a DEPTH-entry FIFO.
// Optional macro ALU_CTRL_M_EN enables decode of the M-extension ops.
module alu_ctrl_decode_queue #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input logic clk,
    input logic rst,
    alu_ctrl_decode_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [31:0] ALU_CTRL_ADD    = 32'd1;
    localparam logic [31:0] ALU_CTRL_SUB    = 32'd2;
    localparam logic [31:0] ALU_CTRL_SLL    = 32'd3;
    localparam logic [31:0] ALU_CTRL_SLT    = 32'd4;
    localparam logic [31:0] ALU_CTRL_SLTU   = 32'd5;
    localparam logic [31:0] ALU_CTRL_XOR    = 32'd6;
    localparam logic [31:0] ALU_CTRL_SRL    = 32'd7;
    localparam logic [31:0] ALU_CTRL_SRA    = 32'd8;
    localparam logic [31:0] ALU_CTRL_OR     = 32'd9;
    localparam logic [31:0] ALU_CTRL_AND    = 32'd10;
    localparam logic [31:0] ALU_CTRL_SEQ    = 32'd11;
    localparam logic [31:0] ALU_CTRL_SNE    = 32'd12;
    localparam logic [31:0] ALU_CTRL_SGE    = 32'd13;
    localparam logic [31:0] ALU_CTRL_SGEU   = 32'd14;
`ifdef ALU_CTRL_M_EN
    localparam logic [31:0] ALU_CTRL_MUL    = 32'd15;
    localparam logic [31:0] ALU_CTRL_MULH   = 32'd16;
    localparam logic [31:0] ALU_CTRL_MULHSU = 32'd17;
    localparam logic [31:0] ALU_CTRL_MULHU  = 32'd18;
    localparam logic [31:0] ALU_CTRL_DIV    = 32'd19;
    localparam logic [31:0] ALU_CTRL_DIVU   = 32'd20;
    localparam logic [31:0] ALU_CTRL_REM    = 32'd21;
    localparam logic [31:0] ALU_CTRL_REMU   = 32'd22;
`endif

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMMED  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef struct packed {
        logic        illegal;
        logic [31:0] alu_ctrl;
    } dec_t;

    typedef struct packed {
        logic [31:0]      alu_ctrl;
        logic             imm_sel;
        logic             is_branch;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    localparam dec_t DEC_ILLEGAL = '{illegal: 1'b1, alu_ctrl: 32'd0};

    function automatic dec_t legal(input logic [31:0] code);
        return '{illegal: 1'b0, alu_ctrl: code};
    endfunction

    // f3 -> base operation; shifts right resolve to SRL here.
    function automatic logic [31:0] base_op(input logic [2:0] f3);
        logic [31:0] code;
        case (f3)
            3'b000:  code = ALU_CTRL_ADD;
            3'b001:  code = ALU_CTRL_SLL;
            3'b010:  code = ALU_CTRL_SLT;
            3'b011:  code = ALU_CTRL_SLTU;
            3'b100:  code = ALU_CTRL_XOR;
            3'b101:  code = ALU_CTRL_SRL;
            3'b110:  code = ALU_CTRL_OR;
            default: code = ALU_CTRL_AND;
        endcase
        return code;
    endfunction

    function automatic dec_t dec_branch(input logic [2:0] f3);
        dec_t d;
        case (f3)
            3'b000:  d = legal(ALU_CTRL_SEQ);
            3'b001:  d = legal(ALU_CTRL_SNE);
            3'b100:  d = legal(ALU_CTRL_SLT);
            3'b101:  d = legal(ALU_CTRL_SGE);
            3'b110:  d = legal(ALU_CTRL_SLTU);
            3'b111:  d = legal(ALU_CTRL_SGEU);
            default: d = DEC_ILLEGAL;
        endcase
        return d;
    endfunction

`ifdef ALU_CTRL_M_EN
    function automatic dec_t dec_muldiv(input logic [2:0] f3);
        dec_t d;
        case (f3)
            3'b000:  d = legal(ALU_CTRL_MUL);
            3'b001:  d = legal(ALU_CTRL_MULH);
            3'b010:  d = legal(ALU_CTRL_MULHSU);
            3'b011:  d = legal(ALU_CTRL_MULHU);
            3'b100:  d = legal(ALU_CTRL_DIV);
            3'b101:  d = legal(ALU_CTRL_DIVU);
            3'b110:  d = legal(ALU_CTRL_REM);
            default: d = legal(ALU_CTRL_REMU);
        endcase
        return d;
    endfunction
`endif

    // The alternate funct7 is only meaningful for SUB and SRA.
    function automatic dec_t dec_op(input logic [6:0] f7, input logic [2:0] f3);
        dec_t d;
        case (f7)
            F7_BASE: d = legal(base_op(f3));
            F7_ALT: begin
                if (f3 == 3'b000)
                    d = legal(ALU_CTRL_SUB);
                else if (f3 == 3'b101)
                    d = legal(ALU_CTRL_SRA);
                else
                    d = DEC_ILLEGAL;
            end
`ifdef ALU_CTRL_M_EN
            F7_MULD: d = dec_muldiv(f3);
`else
            F7_MULD: d = DEC_ILLEGAL;
`endif
            default: d = DEC_ILLEGAL;
        endcase
        return d;
    endfunction

    // Upper immediate bits only constrain the shift encodings.
    function automatic dec_t dec_immed(input logic [6:0] f7, input logic [2:0] f3);
        dec_t d;
        case (f3)
            3'b001: begin
                if (f7 == F7_BASE)
                    d = legal(ALU_CTRL_SLL);
                else
                    d = DEC_ILLEGAL;
            end
            3'b101: begin
                if (f7 == F7_BASE)
                    d = legal(ALU_CTRL_SRL);
                else if (f7 == F7_ALT)
                    d = legal(ALU_CTRL_SRA);
                else
                    d = DEC_ILLEGAL;
            end
            default: d = legal(base_op(f3));
        endcase
        return d;
    endfunction

    function automatic entry_t decode(
        input logic [31:0]      inst,
        input logic [TAG_W-1:0] tag
    );
        entry_t      e;
        dec_t        d;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        opc = inst[6:0];
        f7  = inst[31:25];
        f3  = inst[14:12];
        d   = legal(ALU_CTRL_ADD);
        case (opc)
            OPC_OP:     d = dec_op(f7, f3);
            OPC_IMMED:  d = dec_immed(f7, f3);
            OPC_BRANCH: d = dec_branch(f3);
            default:    d = legal(ALU_CTRL_ADD);
        endcase
        e.alu_ctrl  = d.alu_ctrl;
        e.illegal   = d.illegal;
        e.is_branch = (opc == OPC_BRANCH);
        e.imm_sel   = (opc == OPC_IMMED) || (opc == OPC_LOAD) ||
                      (opc == OPC_STORE) || (opc == OPC_JALR) ||
                      (opc == OPC_AUIPC) || (opc == OPC_LUI);
        e.tag       = tag;
        return e;
    endfunction

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          unused_bits;

    assign unused_bits = ^{bus.in_inst[24:15], bus.in_inst[11:7]};

    assign bus.in_ready  = (count < CW'(DEPTH)) || bus.out_ready;
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Occupancy and pointer bookkeeping; flush drops same-cycle traffic.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Decode at enqueue so the head is already a finished control word.
    always_ff @(posedge clk) begin
        if (push && !rst && !bus.flush)
            mem[wr_ptr] <= decode(bus.in_inst, bus.in_tag);
    end

    assign head = mem[rd_ptr];

    assign bus.out_alu_ctrl  = bus.out_valid ? head.alu_ctrl  : '0;
    assign bus.out_imm_sel   = bus.out_valid ? head.imm_sel   : 1'b0;
    assign bus.out_is_branch = bus.out_valid ? head.is_branch : 1'b0;
    assign bus.out_illegal   = bus.out_valid ? head.illegal   : 1'b0;
    assign bus.out_tag       = bus.out_valid ? head.tag       : '0;
    assign bus.count         = count;
endmodule

// File: tb/tb_alu_ctrl_decode_queue.sv
// tb_alu_ctrl_decode_queue: directed stimulus with hand-computed decode
// expectations, a queue model of the FIFO and per-cycle output checks.
module tb_alu_ctrl_decode_queue;
    localparam int DEPTH = 2;
    localparam int TAG_W = 5;

    localparam logic [31:0] ADD = 1, SUB = 2, SLL = 3, SLT = 4, SLTU = 5;
    localparam logic [31:0] XOR = 6, SRL = 7, SRA = 8, OR = 9, AND = 10;
    localparam logic [31:0] SEQ = 11, SNE = 12, SGE = 13, SGEU = 14;
    localparam logic [31:0] MUL = 15, MULHU = 18, REMU = 22;

    localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;
    localparam logic [6:0] BR = 7'b1100011;

    typedef struct {
        logic [31:0]      alu;
        logic             imm;
        logic             br;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] alu;
        logic        imm;
        logic        br;
        logic        ill;
    } vec_t;

    logic clk;
    logic rst;
    int   passed = 0;
    int   total  = 0;
    exp_t q[$];
    exp_t nxt;
    exp_t e;
    vec_t vt[$];
    logic pu;
    logic po;

    alu_ctrl_decode_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_ctrl_decode_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7,
                                       input logic [2:0] f3,
                                       input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    task automatic add_vec(input logic [31:0] inst, input logic [31:0] alu,
                           input logic imm, input logic br, input logic ill);
        vec_t v;
        v.inst = inst;
        v.alu  = alu;
        v.imm  = imm;
        v.br   = br;
        v.ill  = ill;
        vt.push_back(v);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                         input logic [31:0] alu, input logic imm,
                         input logic br, input logic ill);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_tag   = tag;
        nxt.alu = alu;
        nxt.imm = imm;
        nxt.br  = br;
        nxt.ill = ill;
        nxt.tag = tag;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vec(input vec_t v, input logic [TAG_W-1:0] tag,
                            input logic ordy);
        int tries;
        drive(v.inst, tag, v.alu, v.imm, v.br, v.ill);
        bus.out_ready = ordy;
        #1;
        tries = 0;
        while (!bus.in_ready && tries < 20) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            #1;
            tries++;
        end
        if (tries >= 20) begin
            total++;
            $display("FAIL push_timeout: got busy want ready tag %0d", tag);
        end
        cyc();
        idle();
    endtask

    // Scoreboard: check outputs against the model, then advance the model
    // with the handshake the next rising edge will see.
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
        chk("count", 32'(bus.count), q.size());
        chk("in_ready", 32'(bus.in_ready),
            32'((q.size() < DEPTH) || bus.out_ready));
        if (q.size() != 0) begin
            chk("alu_ctrl", bus.out_alu_ctrl, q[0].alu);
            chk("imm_sel", 32'(bus.out_imm_sel), 32'(q[0].imm));
            chk("is_branch", 32'(bus.out_is_branch), 32'(q[0].br));
            chk("illegal", 32'(bus.out_illegal), 32'(q[0].ill));
            chk("tag", 32'(bus.out_tag), 32'(q[0].tag));
        end else begin
            chk("idle_alu", bus.out_alu_ctrl, 32'd0);
            chk("idle_flags", 32'({bus.out_imm_sel, bus.out_is_branch,
                                   bus.out_illegal, bus.out_tag}), 32'd0);
        end
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            pu = bus.in_valid && ((q.size() < DEPTH) || bus.out_ready);
            po = (q.size() != 0) && bus.out_ready;
            if (po)
                e = q.pop_front();
            if (pu)
                q.push_back(nxt);
        end
    end

    initial begin
        clk           = 1'b0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        nxt           = '{default: '0};

        add_vec(mk(7'h00, 3'b000, OP), ADD, 0, 0, 0);
        add_vec(mk(7'h00, 3'b001, OP), SLL, 0, 0, 0);
        add_vec(mk(7'h00, 3'b101, OP), SRL, 0, 0, 0);
        add_vec(mk(7'h20, 3'b101, OP), SRA, 0, 0, 0);
        add_vec(mk(7'h20, 3'b100, OP), 0, 0, 0, 1);
        add_vec(mk(7'h20, 3'b010, OP), 0, 0, 0, 1);
        add_vec(mk(7'h02, 3'b110, OP), 0, 0, 0, 1);
        add_vec(mk(7'h00, 3'b111, OP), AND, 0, 0, 0);
        add_vec(mk(7'h00, 3'b011, OP), SLTU, 0, 0, 0);
        add_vec(mk(7'h20, 3'b000, OPI), ADD, 1, 0, 0);
        add_vec(mk(7'h20, 3'b001, OPI), 0, 1, 0, 1);
        add_vec(mk(7'h00, 3'b101, OPI), SRL, 1, 0, 0);
        add_vec(mk(7'h30, 3'b101, OPI), 0, 1, 0, 1);
        add_vec(mk(7'h7f, 3'b100, OPI), XOR, 1, 0, 0);
        add_vec(mk(7'h00, 3'b010, OPI), SLT, 1, 0, 0);
        add_vec(mk(7'h20, 3'b111, OPI), AND, 1, 0, 0);
        add_vec(mk(7'h00, 3'b110, OPI), OR, 1, 0, 0);
        add_vec(mk(7'h00, 3'b000, 7'b0110111), ADD, 1, 0, 0);
        add_vec(mk(7'h20, 3'b101, 7'b1101111), ADD, 0, 0, 0);
        add_vec(mk(7'h00, 3'b010, 7'b0000011), ADD, 1, 0, 0);
        add_vec(mk(7'h00, 3'b010, 7'b0100011), ADD, 1, 0, 0);
        add_vec(mk(7'h00, 3'b000, 7'b1100111), ADD, 1, 0, 0);
        add_vec(mk(7'h01, 3'b000, 7'b0010111), ADD, 1, 0, 0);
        add_vec(mk(7'h00, 3'b000, BR), SEQ, 0, 1, 0);
        add_vec(mk(7'h00, 3'b001, BR), SNE, 0, 1, 0);
        add_vec(mk(7'h00, 3'b101, BR), SGE, 0, 1, 0);
        add_vec(mk(7'h00, 3'b110, BR), SLTU, 0, 1, 0);
        add_vec(mk(7'h00, 3'b111, BR), SGEU, 0, 1, 0);
        add_vec(mk(7'h00, 3'b011, BR), 0, 0, 1, 1);
`ifdef ALU_CTRL_M_EN
        add_vec(mk(7'h01, 3'b011, OP), MULHU, 0, 0, 0);
        add_vec(mk(7'h01, 3'b111, OP), REMU, 0, 0, 0);
`else
        add_vec(mk(7'h01, 3'b011, OP), 0, 0, 0, 1);
        add_vec(mk(7'h01, 3'b111, OP), 0, 0, 0, 1);
`endif

        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        cyc();

        drive(32'h40B50533, 5'd3, SUB, 0, 0, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("sub_valid", 32'(bus.out_valid), 1);
        chk("sub_alu", bus.out_alu_ctrl, SUB);
        chk("sub_imm", 32'(bus.out_imm_sel), 0);
        chk("sub_tag", 32'(bus.out_tag), 3);
        chk("sub_count", 32'(bus.count), 1);
        cyc();
        bus.out_ready = 1'b1;
        cyc();

        drive(32'h4032D293, 5'd4, SRA, 1, 0, 0);
        cyc();
        drive(32'h0020C063, 5'd5, SLT, 0, 1, 0);
        @(negedge clk);
        chk("srai_alu", bus.out_alu_ctrl, SRA);
        chk("srai_imm", 32'(bus.out_imm_sel), 1);
        chk("srai_tag", 32'(bus.out_tag), 4);
        cyc();
        idle();
        @(negedge clk);
        chk("blt_alu", bus.out_alu_ctrl, SLT);
        chk("blt_br", 32'(bus.out_is_branch), 1);
        chk("blt_tag", 32'(bus.out_tag), 5);
        cyc();
        bus.out_ready = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            drive(vt[i].inst, TAG_W'(10 + i), vt[i].alu, vt[i].imm,
                  vt[i].br, vt[i].ill);
            cyc();
        end
        drive(vt[DEPTH].inst, TAG_W'(10 + DEPTH), vt[DEPTH].alu,
              vt[DEPTH].imm, vt[DEPTH].br, vt[DEPTH].ill);
        @(negedge clk);
        chk("full_ready", 32'(bus.in_ready), 0);
        chk("full_count", 32'(bus.count), DEPTH);
        cyc();
        bus.out_ready = 1'b1;
        cyc();
        drive(vt[DEPTH+1].inst, TAG_W'(11 + DEPTH), vt[DEPTH+1].alu,
              vt[DEPTH+1].imm, vt[DEPTH+1].br, vt[DEPTH+1].ill);
        @(negedge clk);
        chk("swap_count", 32'(bus.count), DEPTH);
        chk("swap_tag", 32'(bus.out_tag), 11);
        cyc();
        idle();
        repeat (DEPTH + 2) cyc();
        bus.out_ready = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            push_vec(vt[i], TAG_W'(i), (i % 3) != 2);
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) cyc();
        chk("drain_count", 32'(bus.count), 0);
        bus.out_ready = 1'b0;

        drive(32'h0020A063, 5'd7, 0, 0, 1, 1);
        cyc();
        idle();
        @(negedge clk);
        chk("bad_br_valid", 32'(bus.out_valid), 1);
        chk("bad_br_ill", 32'(bus.out_illegal), 1);
        chk("bad_br_alu", bus.out_alu_ctrl, 0);
        cyc();
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;

        drive(vt[0].inst, 5'd8, vt[0].alu, 0, 0, 0);
        cyc();
        drive(vt[1].inst, 5'd9, vt[1].alu, 0, 0, 0);
        cyc();
        drive(vt[2].inst, 5'd10, vt[2].alu, 0, 0, 0);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush_ready", 32'(bus.in_ready), 1);
        cyc();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        idle();
        @(negedge clk);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_valid", 32'(bus.out_valid), 0);
        cyc();
        drive(vt[3].inst, 5'd11, vt[3].alu, 0, 0, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("post_flush_tag", 32'(bus.out_tag), 11);
        chk("post_flush_count", 32'(bus.count), 1);
        cyc();

        rst = 1'b1;
        drive(vt[0].inst, 5'd12, vt[0].alu, 0, 0, 0);
        cyc();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("rst_over_count", 32'(bus.count), 0);
        cyc();

`ifdef ALU_CTRL_M_EN
        drive(32'h023100B3, 5'd13, MUL, 0, 0, 0);
`else
        drive(32'h023100B3, 5'd13, 0, 0, 0, 1);
`endif
        cyc();
        idle();
        @(negedge clk);
`ifdef ALU_CTRL_M_EN
        chk("mul_alu", bus.out_alu_ctrl, MUL);
        chk("mul_ill", 32'(bus.out_illegal), 0);
`else
        chk("mul_alu", bus.out_alu_ctrl, 0);
        chk("mul_ill", 32'(bus.out_illegal), 1);
`endif
        cyc();
        bus.out_ready = 1'b1;
        repeat (2) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_ctrl_decode_queue.md
Name: alu_ctrl_decode_queue

Overview:
Registered, parametrised successor to the combinational ALU-control decoder. It takes 32-bit RV32I instructions under a valid/ready handshake and decodes the ALU control word. Each decoded entry carries its operand-select, branch and illegal flags and is held in a DEPTH-entry FIFO. The block sits between fetch and execute, decoupling them by up to DEPTH instructions, and supports a pipeline flush.

Parameters:
DEPTH, 2, number of FIFO entries (>=1; any value, not required to be a power of two)
TAG_W, 5, width of the opaque sideband tag carried with each instruction

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
flush  in  1  drop all queued entries
in_valid  in  1  instruction offered
in_ready  out  1  block can accept
in_inst  in  32  raw instruction
in_tag  in  TAG_W  sideband tag (e.g. PC index), passed through unchanged
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_alu_ctrl  out  32  ALU_CTRL_* code (word_t)
out_imm_sel  out  1  1 = operand B from immediate (OP_IMMED, LOAD, STORE, JALR, AUIPC, LUI)
out_is_branch  out  1  opcode is BRANCH
out_illegal  out  1  encoding invalid for ALU decode
out_tag  out  TAG_W  tag of head entry
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: count=0, out_valid=0. All payload outputs are 0 while out_valid=0. rst overrides flush and all traffic.
- Push occurs when in_valid&&in_ready. Pop occurs when out_valid&&out_ready.
- in_ready = (count<DEPTH) || out_ready. When full, a simultaneous pop and push is allowed; count is unchanged.
- Latency: an accepted instruction appears at the head no earlier than the next cycle. There is no combinational path from in_* to out_*.
- Order is strict FIFO. out_valid = (count!=0). Head payload stays stable while out_valid && !out_ready.
- Pointers wrap modulo DEPTH.
- flush: count=0 and pointers reset next cycle. A push or pop in the same cycle is discarded, so the push is lost. in_ready is unaffected by flush.
- BRANCH decode by f3:
  - BEQ→SEQ, BNE→SNE, BLT→SLT, BGE→SGE, BLTU→SLTU, BGEU→SGEU.
  - f3 010/011 → alu_ctrl=0, illegal=1.
- OP decode:
  - funct7 0000000 with any f3 gives the base operation.
  - funct7 0100000 is legal only for f3 ADD (gives SUB) and SR (gives SRA).
  - Any other funct7 → illegal=1, alu_ctrl=0.
- OP_IMMED decode:
  - f3 ADD is always ADD; inst[30] is ignored.
  - SL requires inst[31:25]=0000000.
  - SR gives SRL when inst[31:25]=0000000 and SRA when inst[31:25]=0100000; any other value → illegal=1.
- Shift decode: inst[30]=1 selects SRA exclusively. SRL must never be produced for an SRA encoding.
- All other opcodes: alu_ctrl=ALU_CTRL_ADD, illegal=0, is_branch=0.
- Illegal entries are still queued; the consumer raises the trap.

Optional Feature:
ALU_CTRL_M_EN:
- Defined: OP with funct7=0000001 decodes f3 000..111 to ALU_CTRL_MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (codes added in types.sv), with illegal=0.
- Undefined: funct7=0000001 → illegal=1, alu_ctrl=0.
- Default is undefined.

Test Plan:
- Reset then push 0x40B50533 (sub) tag 3 → next cycle out_valid=1, alu_ctrl=ALU_CTRL_SUB, imm_sel=0, tag=3, count=1.
- Push 0x4032D293 (srai) then 0x0020C063 (blt), with out_ready=1 → two outputs in order: SRA with imm_sel=1, then SLT with is_branch=1.
- Hold out_ready=0 and push DEPTH+1 entries → in_ready=0 after DEPTH pushes, count=DEPTH. Release out_ready → simultaneous push/pop keeps count=DEPTH, and FIFO order is preserved across wrap.
- Push 0x0020A063 (branch f3=010) → illegal=1, alu_ctrl=0, still delivered.
- With count=2, assert flush together with in_valid → next cycle count=0 and out_valid=0; the pushed entry is absent.
- Push 0x023100B3 (mul): with ALU_CTRL_M_EN → ALU_CTRL_MUL, illegal=0; without it → illegal=1, alu_ctrl=0.
